// File: rtl/wash_phase_timer.sv
// Purpose: per-phase countdown timer for a washing-machine controller; raises the done flag of the active timed phase.
// Latency: all outputs registered; a phase change is reflected one clk edge after state_code changes.
// Backpressure: none; state_code is sampled every clk, so the controller simply moves on when it sees a done flag.
//
// Ports:
//   clk         - system clock (sole clock)
//   reset       - asynchronous active-high reset
//   state_code  - controller state: 001 idle, 011 fill, 111 rinse, 110 drain, 100 spin, 000 alarm
//   wash        - rinse time elapsed  (only while state_code = 111)
//   water       - drain time elapsed  (only while state_code = 110)
//   dewater     - spin time elapsed   (only while state_code = 100)
//   alarm       - alarm time elapsed  (only while state_code = 000)
//   remain_sec  - whole seconds left in the current timed phase
//   tick        - one-clk pulse at each 1 s boundary of a running timed phase
module wash_phase_timer #(
    parameter int TICK_DIV  = 50000000,
    parameter int T_WASH    = 20,
    parameter int T_WATER   = 10,
    parameter int T_DEWATER = 15,
    parameter int T_ALARM   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state_code,
    output logic       wash,
    output logic       water,
    output logic       dewater,
    output logic       alarm,
    output logic [7:0] remain_sec,
    output logic       tick
);

    // Prescaler wide enough to hold TICK_DIV-1 (TICK_DIV >= 2 keeps this >= 1).
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        CODE_ALARM = 3'b000,
        CODE_IDLE  = 3'b001,
        CODE_FILL  = 3'b011,
        CODE_SPIN  = 3'b100,
        CODE_DRAIN = 3'b110,
        CODE_RINSE = 3'b111
    } code_e;

    // Bit positions of the done flags inside done_q.
    localparam int DN_WASH    = 0;
    localparam int DN_WATER   = 1;
    localparam int DN_DEWATER = 2;
    localparam int DN_ALARM   = 3;

    logic [2:0]    prev_code;
    logic [PW-1:0] prescaler;
    logic [3:0]    done_q;

    // Decode of the code currently applied.
    logic       cur_timed;
    logic [7:0] cur_dur;
    logic [3:0] cur_sel;

    always_comb begin
        cur_timed = 1'b0;
        cur_dur   = 8'd0;
        cur_sel   = 4'b0000;
        case (state_code)
            CODE_RINSE: begin
                cur_timed        = 1'b1;
                cur_dur          = 8'(T_WASH);
                cur_sel[DN_WASH] = 1'b1;
            end
            CODE_DRAIN: begin
                cur_timed         = 1'b1;
                cur_dur           = 8'(T_WATER);
                cur_sel[DN_WATER] = 1'b1;
            end
            CODE_SPIN: begin
                cur_timed           = 1'b1;
                cur_dur             = 8'(T_DEWATER);
                cur_sel[DN_DEWATER] = 1'b1;
            end
            CODE_ALARM: begin
                cur_timed         = 1'b1;
                cur_dur           = 8'(T_ALARM);
                cur_sel[DN_ALARM] = 1'b1;
            end
            default: begin
                // idle, fill and the unused codes 010/101 are untimed
            end
        endcase
    end

    logic phase_change;
    logic phase_done;
    logic pre_wrap;

    assign phase_change = (state_code != prev_code);
    assign phase_done   = |done_q;
    assign pre_wrap     = (prescaler == PRE_LAST);

    // Priority: untimed clears everything, then a phase change reloads
    // (beating any coincident wrap), then a finished phase freezes, then
    // the countdown proper.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_code  <= CODE_IDLE;
            prescaler  <= '0;
            remain_sec <= 8'd0;
            tick       <= 1'b0;
            done_q     <= 4'b0000;
        end else begin
            prev_code <= state_code;
            tick      <= 1'b0;
            if (!cur_timed) begin
                prescaler  <= '0;
                remain_sec <= 8'd0;
                done_q     <= 4'b0000;
            end else if (phase_change) begin
                prescaler  <= '0;
                remain_sec <= cur_dur;
                done_q     <= 4'b0000;
            end else if (phase_done) begin
                // Finished: hold done, remain_sec stays 0, prescaler stopped.
                prescaler <= prescaler;
            end else if (remain_sec == 8'd0) begin
                // Only reachable right after loading a zero duration.
                done_q <= cur_sel;
            end else if (pre_wrap) begin
                prescaler  <= '0;
                tick       <= 1'b1;
                remain_sec <= remain_sec - 8'd1;
                if (remain_sec == 8'd1) begin
                    done_q <= cur_sel;
                end
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    assign wash    = done_q[DN_WASH];
    assign water   = done_q[DN_WATER];
    assign dewater = done_q[DN_DEWATER];
    assign alarm   = done_q[DN_ALARM];

endmodule

// File: tb/tb_wash_phase_timer.sv
// Purpose: self-checking bench for wash_phase_timer with short tick and phase durations.
// Latency: checks every cycle on the falling edge after the rising edge that updates the DUT.
// Backpressure: n/a.
module tb_wash_phase_timer;

    localparam int TD  = 4;
    localparam int TWA = 3;
    localparam int TWT = 2;
    localparam int TDW = 1;
    localparam int TAL = 0;

    logic       clk;
    logic       reset;
    logic [2:0] state_code;
    logic       wash, water, dewater, alarm, tick;
    logic [7:0] remain_sec;

    wash_phase_timer #(
        .TICK_DIV (TD),
        .T_WASH   (TWA),
        .T_WATER  (TWT),
        .T_DEWATER(TDW),
        .T_ALARM  (TAL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .state_code(state_code),
        .wash      (wash),
        .water     (water),
        .dewater   (dewater),
        .alarm     (alarm),
        .remain_sec(remain_sec),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    // Elapsed-time view: m_n counts clk edges since the current code was
    // first applied; every output follows from that count and the duration.
    logic [2:0] m_prev;
    int         m_n;

    task automatic m_reset();
        m_prev = 3'b001;
        m_n    = 0;
    endtask

    task automatic m_edge(input logic [2:0] c);
        if (c !== m_prev) m_n = 0;
        else if (m_n < 100000) m_n = m_n + 1;
        m_prev = c;
    endtask

    task automatic model_out(input logic [2:0] c, input int n,
                             output logic [7:0] rem, output logic tk, output logic [3:0] dn);
        int d, idx, k;
        rem = 8'd0; tk = 1'b0; dn = 4'b0000;
        d = -1; idx = 0;
        case (c)
            3'b111: begin d = TWA; idx = 0; end
            3'b110: begin d = TWT; idx = 1; end
            3'b100: begin d = TDW; idx = 2; end
            3'b000: begin d = TAL; idx = 3; end
            default: d = -1;
        endcase
        if (d < 0) return;
        if (d == 0) begin
            dn[idx] = (n >= 1);
            return;
        end
        k   = n / TD;
        rem = 8'(d - ((k < d) ? k : d));
        tk  = (n > 0) && (n % TD == 0) && (k <= d);
        dn[idx] = (n >= TD * d);
    endtask

    // ---------------- checking helpers ----------------
    task automatic check_out(input string nm, input logic [7:0] er, input logic et, input logic [3:0] ed);
        logic [3:0] ad;
        ad = {alarm, dewater, water, wash};
        vectors++;
        if (remain_sec !== er || tick !== et || ad !== ed) begin
            miscompares++;
            $display("FAIL %s: got remain=%0d tick=%b done=%b, expected remain=%0d tick=%b done=%b",
                     nm, remain_sec, tick, ad, er, et, ed);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge after checking.
    task automatic cyc(input logic [2:0] c, input string nm);
        logic [7:0] er; logic et; logic [3:0] ed;
        state_code = c;
        @(posedge clk);
        m_edge(c);
        @(negedge clk);
        model_out(c, m_n, er, et, ed);
        check_out(nm, er, et, ed);
    endtask

    // Asynchronous reset pulse spanning one rising edge; called on a falling edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1 check_out("reset_async", 8'd0, 1'b0, 4'b0000);
        @(posedge clk);
        #1 check_out("reset_held", 8'd0, 1'b0, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [2:0] code;
        logic [7:0] rem;
        logic       tk;
        logic [3:0] dn;   // {alarm, dewater, water, wash}
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [2:0] c, input int r, input logic t, input logic [3:0] d);
        vec_t v;
        v.code = c; v.rem = 8'(r); v.tk = t; v.dn = d;
        tbl.push_back(v);
    endtask

    initial begin
        // Full cycle; each new code applied right after the previous done is seen.
        add(3'b001, 0, 0, 4'b0000);
        add(3'b011, 0, 0, 4'b0000);
        add(3'b111, 3, 0, 4'b0000); add(3'b111, 3, 0, 4'b0000);
        add(3'b111, 3, 0, 4'b0000); add(3'b111, 3, 0, 4'b0000);
        add(3'b111, 2, 1, 4'b0000); add(3'b111, 2, 0, 4'b0000);
        add(3'b111, 2, 0, 4'b0000); add(3'b111, 2, 0, 4'b0000);
        add(3'b111, 1, 1, 4'b0000); add(3'b111, 1, 0, 4'b0000);
        add(3'b111, 1, 0, 4'b0000); add(3'b111, 1, 0, 4'b0000);
        add(3'b111, 0, 1, 4'b0001); add(3'b111, 0, 0, 4'b0001);
        add(3'b111, 0, 0, 4'b0001);
        add(3'b110, 2, 0, 4'b0000); add(3'b110, 2, 0, 4'b0000);
        add(3'b110, 2, 0, 4'b0000); add(3'b110, 2, 0, 4'b0000);
        add(3'b110, 1, 1, 4'b0000); add(3'b110, 1, 0, 4'b0000);
        add(3'b110, 1, 0, 4'b0000); add(3'b110, 1, 0, 4'b0000);
        add(3'b110, 0, 1, 4'b0010);
        add(3'b100, 1, 0, 4'b0000); add(3'b100, 1, 0, 4'b0000);
        add(3'b100, 1, 0, 4'b0000); add(3'b100, 1, 0, 4'b0000);
        add(3'b100, 0, 1, 4'b0100); add(3'b100, 0, 0, 4'b0100);
        add(3'b000, 0, 0, 4'b0000); add(3'b000, 0, 0, 4'b1000);
        add(3'b000, 0, 0, 4'b1000);
        add(3'b001, 0, 0, 4'b0000); add(3'b011, 0, 0, 4'b0000);

        reset      = 1'b1;
        state_code = 3'b001;
        m_reset();
        @(negedge clk);
        check_out("reset_state", 8'd0, 1'b0, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            state_code = tbl[i].code;
            @(posedge clk);
            m_edge(tbl[i].code);
            @(negedge clk);
            check_out($sformatf("table[%0d]", i), tbl[i].rem, tbl[i].tk, tbl[i].dn);
        end

        // Abandon rinse after 5 clk; wash must never rise, re-entry reloads.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(3'b111, "abandon_run");
            chk("abandon_no_wash", int'(wash), 0);
        end
        cyc(3'b001, "abandon_idle");
        chk("abandon_remain", int'(remain_sec), 0);
        chk("abandon_wash", int'(wash), 0);
        cyc(3'b111, "abandon_reenter");
        chk("reenter_remain", int'(remain_sec), TWA);

        // Phase change on the edge where the prescaler would wrap.
        do_reset();
        for (int i = 0; i < TD; i++) cyc(3'b111, "wrap_setup");
        cyc(3'b110, "wrap_change");
        chk("wrap_change_tick", int'(tick), 0);
        chk("wrap_change_remain", int'(remain_sec), TWT);
        for (int i = 0; i < TD - 1; i++) begin
            cyc(3'b110, "wrap_restart");
            chk("wrap_restart_no_tick", int'(tick), 0);
        end
        cyc(3'b110, "wrap_first_tick");
        chk("wrap_first_tick", int'(tick), 1);
        chk("wrap_first_remain", int'(remain_sec), TWT - 1);

        // Reset pulse during drain with one second left.
        do_reset();
        for (int i = 0; i <= TD; i++) cyc(3'b110, "drain_run");
        chk("drain_remain_1", int'(remain_sec), 1);
        do_reset();
        cyc(3'b110, "drain_restart");
        chk("drain_restart_remain", int'(remain_sec), TWT);

        // Randomized code sequences with occasional reset pulses.
        for (int b = 0; b < 70; b++) begin
            logic [2:0] c;
            int hold;
            c    = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 18);
            for (int j = 0; j < hold; j++) cyc(c, "random");
            if ($urandom_range(0, 9) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wash_phase_timer.md
WASH_PHASE_TIMER -- requirements
Module: wash_phase_timer

Parameters
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000: clk cycles per 1 s tick, legal range 2 or more.
REQ-002 The block SHALL have parameter T_WASH, default 20: rinse duration in seconds, legal range 0-255.
REQ-003 The block SHALL have parameter T_WATER, default 10: drain duration in seconds, legal range 0-255.
REQ-004 The block SHALL have parameter T_DEWATER, default 15: spin duration in seconds, legal range 0-255.
REQ-005 The block SHALL have parameter T_ALARM, default 5: alarm duration in seconds, legal range 0-255.

Interface
REQ-006 The block SHALL have port clk, input, 1 bit: system clock, sole clock.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-008 The block SHALL have port state_code, input, 3 bits: controller state (001 idle, 011 fill, 111 rinse, 110 drain, 100 spin, 000 alarm).
REQ-009 The block SHALL have port wash, output, 1 bit: rinse time elapsed, active high.
REQ-010 The block SHALL have port water, output, 1 bit: drain time elapsed, active high.
REQ-011 The block SHALL have port dewater, output, 1 bit: spin time elapsed, active high.
REQ-012 The block SHALL have port alarm, output, 1 bit: alarm time elapsed, active high.
REQ-013 The block SHALL have port remain_sec, output, 8 bits: seconds remaining in the current timed phase.
REQ-014 The block SHALL have port tick, output, 1 bit: one-clk pulse at each 1 s boundary of a running timed phase.

Function
REQ-015 Timed phases SHALL be 111, 110, 100 and 000, with durations T_WASH, T_WATER, T_DEWATER and T_ALARM respectively.
REQ-016 Untimed codes SHALL be 001, 011 and all others (010, 101).
- While in an untimed code: prescaler held at 0, remain_sec = 0, tick = 0, all done outputs = 0.
REQ-017 The block SHALL register state_code every clk into prev_code.
- A phase change is state_code != prev_code.
REQ-018 On a phase change into a timed code, the block SHALL, at that clk edge:
- load remain_sec with the duration for that code;
- clear the prescaler;
- clear all done outputs.
REQ-019 The prescaler SHALL count 0 to TICK_DIV-1 and wrap while a timed phase runs with remain_sec > 0.
- tick SHALL assert for exactly one clk on the wrap.
REQ-020 On each tick, remain_sec SHALL decrement by 1.
- On the tick that takes remain_sec from 1 to 0, the done output for the current code SHALL assert at the same edge.
REQ-021 Once asserted, a done output SHALL stay high, with remain_sec held at 0 and the prescaler stopped, until the next phase change or reset.
REQ-022 A duration of 0 SHALL assert the done output on the clk edge after the load, with no tick.
REQ-023 At most one done output SHALL be high at any time, and only the one matching the current state_code.
REQ-024 If a phase change and a prescaler wrap fall on the same edge, the phase change SHALL win.
- The block SHALL reload, emit no tick and apply no decrement.
REQ-025 If the controller returns to idle mid-phase, the block SHALL abandon the count (per REQ-016) at the next edge, with no done pulse.
REQ-026 Re-entering the same timed code after any other code SHALL restart the full duration.
REQ-027 remain_sec SHALL never underflow below 0 or wrap to 255.
REQ-028 All outputs SHALL be registered; there SHALL be no combinational path from state_code to any output.

Reset
REQ-029 While reset is high, regardless of clk, the block SHALL hold:
- prev_code = 001 and prescaler = 0;
- remain_sec = 0 and tick = 0;
- wash = water = dewater = alarm = 0.
REQ-030 After reset deasserts with state_code = 111, the block SHALL treat the first edge as a phase change and load T_WASH.
REQ-031 Reset asserted mid-count SHALL discard the count.
- No done output may assert while reset is high.

Verification (TICK_DIV=4, T_WASH=3, T_WATER=2, T_DEWATER=1, T_ALARM=0)
REQ-032 Reset, then state_code 001 -> 111: remain_sec goes 3, 2, 1, 0, with ticks 4 clk apart.
- wash rises with the third tick and stays high until state_code -> 110.
- water then rises 8 clk after the change.
REQ-033 Full cycle 001, 011, 111, 110, 100, 000, 001, with each code applied when the previous done is seen:
- exactly one done high at a time, in the order wash, water, dewater, alarm;
- alarm high 1 clk after entering 000;
- all outputs 0 in 001 and 011.
REQ-034 state_code 111, then 001 after 5 clk: remain_sec = 0 next edge, wash never asserts.
- Returning to 111 reloads 3.
REQ-035 Phase change 111 -> 110 on the same edge as a prescaler wrap: no tick, remain_sec = 2, and the prescaler restarts from 0.
REQ-036 Reset pulse of 1 clk during drain with remain_sec = 1: all outputs 0 immediately (asynchronous).
- With 110 still applied, the count restarts at 2 after release.
